// File: rtl/ring_fracture_sched_if.sv
// Bus bundle for the ring fracture scheduler: sample inputs, threshold,
// clear strobes and sticky status outputs.
interface ring_fracture_sched_if #(
  parameter int NCH = 8,
  parameter int DW  = 16
);
  logic [NCH*DW-1:0] ph_ring;
  logic [NCH-1:0]    ph_vld;
  logic [DW-1:0]     cfg_ring_th;
  logic [NCH-1:0]    clr_fracture;
  logic [NCH-1:0]    stu_fracture;
  logic [NCH-1:0]    stu_overrun;
  logic              busy;

  modport master (
    output ph_ring, ph_vld, cfg_ring_th, clr_fracture,
    input  stu_fracture, stu_overrun, busy
  );

  modport slave (
    input  ph_ring, ph_vld, cfg_ring_th, clr_fracture,
    output stu_fracture, stu_overrun, busy
  );
endinterface

// File: rtl/ring_fracture_sched.sv
// Shared-comparator scheduler for the phase ring channels. Each channel holds
// one sample; a round-robin arbiter feeds one pending sample per clock into a
// single below-threshold comparator whose hits are debounced per channel into
// sticky fracture flags. Overwriting an unserviced sample raises sticky overrun.
module ring_fracture_sched #(
  parameter int NCH     = 8,
  parameter int DW      = 16,
  parameter int DEB_CNT = 3
) (
  input logic             clk_sys,
  input logic             rst_n,
  ring_fracture_sched_if.slave bus
);
  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [2:0] DEB = 3'(DEB_CNT);

  logic [NCH-1:0] pend;
  logic [DW-1:0]  hold [NCH];
  logic [2:0]     cnt  [NCH];
  logic [PW-1:0]  ptr;
  logic [NCH-1:0] fracture;
  logic [NCH-1:0] overrun;

  logic           gnt_vld;
  logic [PW-1:0]  gnt_idx;
  logic [NCH-1:0] gnt_oh;
  logic           hit;
  logic [2:0]     cnt_cur;
  logic [2:0]     cnt_inc;
  logic [2:0]     cnt_next;
  logic [NCH-1:0] set_frac;
  logic [NCH-1:0] set_ovr;

  // Round-robin search for the first pending channel starting at ptr.
  always_comb begin
    logic [PW-1:0] idx;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    for (int k = 0; k < NCH; k++) begin
      idx = PW'((int'(ptr) + k) % NCH);
      if (!gnt_vld && pend[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx;
      end
    end
  end

  // Threshold compare of the granted sample and debounce-counter next state.
  always_comb begin
    gnt_oh = '0;
    if (gnt_vld) gnt_oh[gnt_idx] = 1'b1;
    cnt_cur  = cnt[gnt_idx];
    cnt_inc  = cnt_cur + 3'd1;
    hit      = gnt_vld && (hold[gnt_idx] < bus.cfg_ring_th);
    cnt_next = !hit ? 3'd0 : ((cnt_cur >= DEB) ? DEB : cnt_inc);
    set_frac = (hit && (cnt_inc == DEB)) ? gnt_oh : '0;
    set_ovr  = pend & ~gnt_oh & bus.ph_vld;
  end

  // Capture, arbitration pointer, debounce counters and sticky status.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      pend     <= '0;
      ptr      <= '0;
      fracture <= '0;
      overrun  <= '0;
      for (int i = 0; i < NCH; i++) begin
        hold[i] <= '0;
        cnt[i]  <= '0;
      end
    end else begin
      if (gnt_vld) ptr <= (gnt_idx == PW'(NCH - 1)) ? '0 : gnt_idx + PW'(1);
      for (int i = 0; i < NCH; i++) begin
        if (bus.ph_vld[i]) begin
          hold[i] <= bus.ph_ring[i*DW +: DW];
          pend[i] <= 1'b1;
        end else if (gnt_oh[i]) begin
          pend[i] <= 1'b0;
        end
        if (set_ovr[i])               overrun[i] <= 1'b1;
        else if (bus.clr_fracture[i]) overrun[i] <= 1'b0;
        if (set_frac[i])              fracture[i] <= 1'b1;
        else if (bus.clr_fracture[i]) fracture[i] <= 1'b0;
        if (bus.clr_fracture[i])      cnt[i] <= '0;
        else if (gnt_oh[i])           cnt[i] <= cnt_next;
      end
    end
  end

  assign bus.stu_fracture = fracture;
  assign bus.stu_overrun  = overrun;
  assign bus.busy         = |pend;
endmodule

// File: tb/tb_ring_fracture_sched.sv
// Scenario bench for ring_fracture_sched: expected grant order is queued as
// stimulus is applied and matched against grants seen from the design.
module tb_ring_fracture_sched;
  localparam int NCH = 8;
  localparam int DW  = 16;

  logic clk_sys = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;
  int   exp_q[$];
  int   obs_q[$];

  always #5 clk_sys = ~clk_sys;

  ring_fracture_sched_if #(.NCH(NCH), .DW(DW)) bus ();

  ring_fracture_sched #(.NCH(NCH), .DW(DW), .DEB_CNT(3)) dut (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  // Grant monitor, sampled mid-cycle while the grant is stable.
  always @(negedge clk_sys) begin
    if (rst_n && dut.gnt_vld) obs_q.push_back(int'(dut.gnt_idx));
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic hit_ch(input int ch, input logic [DW-1:0] val);
    bus.ph_ring[ch*DW +: DW] = val;
    bus.ph_vld = NCH'(1) << ch;
    exp_q.push_back(ch);
    tick();
    bus.ph_vld = '0;
    tick();
  endtask

  task automatic test_reset();
    bus.ph_ring = '0;
    bus.ph_vld = '0;
    bus.cfg_ring_th = 16'h1000;
    bus.clr_fracture = '0;
    rst_n = 1'b0;
    tick();
    tick();
    vectors++;
    if (bus.stu_fracture !== 8'h00 || bus.stu_overrun !== 8'h00 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_status: got frac=%h ovr=%h busy=%b, expected 00 00 0",
               bus.stu_fracture, bus.stu_overrun, bus.busy);
    end
    vectors++;
    if (dut.ptr !== 3'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_ptr: got %0d, expected 0", dut.ptr);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_debounce();
    logic [7:0] exp_frac;
    int e, o;
    obs_q.delete();
    bus.cfg_ring_th = 16'h1000;
    for (int s = 0; s < 3; s++) begin
      bus.ph_ring[DW-1:0] = 16'h0FFF;
      bus.ph_vld = 8'h01;
      exp_q.push_back(0);
      tick();
      bus.ph_vld = '0;
      vectors++;
      if (bus.stu_fracture !== 8'h00) begin
        miscompares++;
        $display("[TB] FAIL deb_sample%0d_edge: got %h, expected 00", s, bus.stu_fracture);
      end
      tick();
      exp_frac = (s == 2) ? 8'h01 : 8'h00;
      vectors++;
      if (bus.stu_fracture !== exp_frac) begin
        miscompares++;
        $display("[TB] FAIL deb_sample%0d_next: got %h, expected %h", s, bus.stu_fracture, exp_frac);
      end
      tick();
      tick();
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (obs_q.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL deb_grant: got none, expected ch%0d", e);
      end else begin
        o = obs_q.pop_front();
        if (o != e) begin
          miscompares++;
          $display("[TB] FAIL deb_grant: got ch%0d, expected ch%0d", o, e);
        end
      end
    end
    vectors++;
    if (obs_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL deb_extra_grants: got %0d, expected 0", obs_q.size());
    end
  endtask

  task automatic test_equal_miss();
    logic [DW-1:0] vals [6];
    logic [7:0]    expf [6];
    vals = '{16'h0FFF, 16'h0FFF, 16'h1000, 16'h0FFF, 16'h0FFF, 16'h0FFF};
    expf = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
    bus.clr_fracture = 8'h01;
    tick();
    bus.clr_fracture = '0;
    vectors++;
    if (bus.stu_fracture !== 8'h00) begin
      miscompares++;
      $display("[TB] FAIL eq_clear: got %h, expected 00", bus.stu_fracture);
    end
    for (int s = 0; s < 6; s++) begin
      hit_ch(0, vals[s]);
      vectors++;
      if (bus.stu_fracture !== expf[s]) begin
        miscompares++;
        $display("[TB] FAIL eq_step%0d: got %h, expected %h", s, bus.stu_fracture, expf[s]);
      end
    end
    exp_q.delete();
  endtask

  task automatic test_round_robin();
    int busy_cycles;
    int e, o;
    do_reset();
    bus.cfg_ring_th = 16'h1000;
    bus.ph_ring = '0;
    bus.ph_vld = 8'hFF;
    for (int c = 0; c < NCH; c++) exp_q.push_back(c);
    tick();
    bus.ph_vld = '0;
    busy_cycles = 0;
    for (int c = 0; c < 10; c++) begin
      if (bus.busy === 1'b1) busy_cycles++;
      if (c == 1) begin
        vectors++;
        if (dut.ptr !== 3'd1) begin
          miscompares++;
          $display("[TB] FAIL rr_ptr_step: got %0d, expected 1", dut.ptr);
        end
      end
      tick();
    end
    vectors++;
    if (busy_cycles != 8) begin
      miscompares++;
      $display("[TB] FAIL rr_busy_len: got %0d, expected 8", busy_cycles);
    end
    vectors++;
    if (dut.ptr !== 3'd0) begin
      miscompares++;
      $display("[TB] FAIL rr_ptr_wrap: got %0d, expected 0", dut.ptr);
    end
    vectors++;
    if (bus.stu_fracture !== 8'h00) begin
      miscompares++;
      $display("[TB] FAIL rr_frac: got %h, expected 00", bus.stu_fracture);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (obs_q.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL rr_grant: got none, expected ch%0d", e);
      end else begin
        o = obs_q.pop_front();
        if (o != e) begin
          miscompares++;
          $display("[TB] FAIL rr_grant: got ch%0d, expected ch%0d", o, e);
        end
      end
    end
    vectors++;
    if (obs_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL rr_extra_grants: got %0d, expected 0", obs_q.size());
    end
  endtask

  task automatic test_overrun();
    int e, o;
    do_reset();
    bus.cfg_ring_th = 16'h1000;
    hit_ch(2, 16'h0FFF);
    hit_ch(2, 16'h0FFF);
    bus.ph_ring[0*DW +: DW] = 16'h2000;
    bus.ph_ring[1*DW +: DW] = 16'h2000;
    bus.ph_vld = 8'h03;
    exp_q.push_back(0);
    exp_q.push_back(1);
    tick();
    bus.ph_ring[2*DW +: DW] = 16'h0FFF;
    bus.ph_vld = 8'h04;
    tick();
    vectors++;
    if (bus.stu_overrun !== 8'h00) begin
      miscompares++;
      $display("[TB] FAIL ovr_first: got %h, expected 00", bus.stu_overrun);
    end
    bus.ph_ring[2*DW +: DW] = 16'h2000;
    bus.ph_vld = 8'h04;
    exp_q.push_back(2);
    tick();
    bus.ph_vld = '0;
    vectors++;
    if (bus.stu_overrun !== 8'h04) begin
      miscompares++;
      $display("[TB] FAIL ovr_set: got %h, expected 04", bus.stu_overrun);
    end
    tick();
    tick();
    vectors++;
    if (bus.stu_fracture !== 8'h00 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL ovr_newest_kept: got frac=%h busy=%b, expected 00 0",
               bus.stu_fracture, bus.busy);
    end
    bus.clr_fracture = 8'h04;
    tick();
    bus.clr_fracture = '0;
    bus.ph_ring[0*DW +: DW] = 16'h2000;
    bus.ph_vld = 8'h01;
    exp_q.push_back(0);
    tick();
    exp_q.push_back(0);
    tick();
    bus.ph_vld = '0;
    vectors++;
    if (bus.stu_overrun !== 8'h00 || bus.busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL ovr_grant_same_cycle: got ovr=%h busy=%b, expected 00 1",
               bus.stu_overrun, bus.busy);
    end
    tick();
    tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (obs_q.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL ovr_grant: got none, expected ch%0d", e);
      end else begin
        o = obs_q.pop_front();
        if (o != e) begin
          miscompares++;
          $display("[TB] FAIL ovr_grant: got ch%0d, expected ch%0d", o, e);
        end
      end
    end
    vectors++;
    if (obs_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL ovr_extra_grants: got %0d, expected 0", obs_q.size());
    end
  endtask

  task automatic test_clear_set();
    do_reset();
    bus.cfg_ring_th = 16'h1000;
    for (int s = 0; s < 3; s++) hit_ch(0, 16'h0ABC);
    vectors++;
    if (bus.stu_fracture !== 8'h01) begin
      miscompares++;
      $display("[TB] FAIL clr_pre: got %h, expected 01", bus.stu_fracture);
    end
    bus.clr_fracture = 8'h01;
    tick();
    bus.clr_fracture = '0;
    vectors++;
    if (bus.stu_fracture !== 8'h00) begin
      miscompares++;
      $display("[TB] FAIL clr_alone: got %h, expected 00", bus.stu_fracture);
    end
    hit_ch(0, 16'h0ABC);
    hit_ch(0, 16'h0ABC);
    bus.ph_ring[DW-1:0] = 16'h0ABC;
    bus.ph_vld = 8'h01;
    tick();
    bus.ph_vld = '0;
    bus.clr_fracture = 8'h01;
    tick();
    bus.clr_fracture = '0;
    vectors++;
    if (bus.stu_fracture !== 8'h01) begin
      miscompares++;
      $display("[TB] FAIL clr_set_same_edge: got %h, expected 01", bus.stu_fracture);
    end
    bus.clr_fracture = 8'h01;
    tick();
    bus.clr_fracture = '0;
    vectors++;
    if (bus.stu_fracture !== 8'h00) begin
      miscompares++;
      $display("[TB] FAIL clr_after_set: got %h, expected 00", bus.stu_fracture);
    end
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.cfg_ring_th = 16'h1000;
    for (int s = 0; s < 3; s++) hit_ch(7, 16'h0001);
    bus.ph_ring[6*DW +: DW] = 16'h3000;
    bus.ph_ring[7*DW +: DW] = 16'h3000;
    bus.ph_vld = 8'hC0;
    tick();
    bus.ph_vld = 8'h80;
    tick();
    bus.ph_vld = '0;
    tick();
    tick();
    vectors++;
    if (bus.stu_overrun !== 8'h80 || bus.stu_fracture !== 8'h80) begin
      miscompares++;
      $display("[TB] FAIL mid_pre_status: got ovr=%h frac=%h, expected 80 80",
               bus.stu_overrun, bus.stu_fracture);
    end
    bus.ph_ring = '0;
    bus.ph_vld = 8'h1F;
    tick();
    bus.ph_vld = '0;
    tick();
    vectors++;
    if (bus.busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL mid_busy_pre: got %b, expected 1", bus.busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.busy !== 1'b0 || bus.stu_fracture !== 8'h00 || bus.stu_overrun !== 8'h00) begin
      miscompares++;
      $display("[TB] FAIL mid_async_clear: got busy=%b frac=%h ovr=%h, expected 0 00 00",
               bus.busy, bus.stu_fracture, bus.stu_overrun);
    end
    vectors++;
    if (dut.ptr !== 3'd0) begin
      miscompares++;
      $display("[TB] FAIL mid_ptr: got %0d, expected 0", dut.ptr);
    end
    @(negedge clk_sys);
    rst_n = 1'b1;
    obs_q.delete();
    exp_q.delete();
    for (int c = 0; c < 6; c++) tick();
    vectors++;
    if (obs_q.size() != 0 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL mid_stale_grant: got grants=%0d busy=%b, expected 0 0",
               obs_q.size(), bus.busy);
    end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_equal_miss();
    test_round_robin();
    test_overrun();
    test_clear_set();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
